// File: rtl/alu_share_sched.sv
// Round-robin sequencer for the shared 32-bit logic/compare unit; logic ops respond 2 cycles after grant, compares 3.
// Grants only from IDLE; the response is held in DONE until resp_ack, which stalls all new grants.
module alu_share_sched #(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req0_cls,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  input  logic        req1_cls,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic        resp_err,
  input  logic        resp_ack
);

  typedef enum logic [2:0] {IDLE, LOGIC, SUB, EVAL, DONE} state_t;

  state_t      state;
  logic        prio;
  logic [2:0]  cur_op;
  logic [31:0] cur_a;
  logic [31:0] cur_b;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;

  logic        can_grant;
  logic        sel_cls;
  logic [2:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [31:0] diff;
  logic        lt;
  logic        cond;
  logic [31:0] logic_res;
  logic        logic_err;
  logic        cmp_err;

  // Grants are gated by reset so both pulses read low while rst_n is asserted.
  assign can_grant = rst_n && (state == IDLE);
  assign gnt0      = can_grant && req0_valid && (!req1_valid || !prio);
  assign gnt1      = can_grant && req1_valid && (!req0_valid || prio);

  assign sel_cls = gnt1 ? req1_cls : req0_cls;
  assign sel_op  = gnt1 ? req1_op  : req0_op;
  assign sel_a   = gnt1 ? req1_a   : req0_a;
  assign sel_b   = gnt1 ? req1_b   : req0_b;

  assign diff      = cur_a - cur_b;
  assign lt        = flag_n ^ flag_v;
  assign logic_err = cur_op[2] | (cur_op[1:0] == 2'b11);
  assign cmp_err   = cur_op[2] & cur_op[1];

  always_comb begin
    logic_res = '0;
    case (cur_op[1:0])
      2'b00:   logic_res = cur_a & cur_b;
      2'b01:   logic_res = cur_a | cur_b;
      2'b10:   logic_res = cur_a ^ cur_b;
      default: logic_res = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (cur_op)
      3'b000:  cond = flag_z;
      3'b001:  cond = !flag_z;
      3'b010:  cond = flag_z | lt;
      3'b011:  cond = lt;
      3'b100:  cond = !lt;
      3'b101:  cond = !flag_z & !lt;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prio       <= PRIO_RESET;
      cur_op     <= '0;
      cur_a      <= '0;
      cur_b      <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_v     <= 1'b0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            cur_op  <= sel_op;
            cur_a   <= sel_a;
            cur_b   <= sel_b;
            resp_id <= gnt1;
            prio    <= ~gnt1;
            busy    <= 1'b1;
            state   <= sel_cls ? SUB : LOGIC;
          end
        end
        LOGIC: begin
          resp_data  <= logic_err ? 32'h0 : logic_res;
          resp_err   <= logic_err;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        SUB: begin
          flag_z <= (diff == 32'h0);
          flag_n <= diff[31];
          flag_v <= (cur_a[31] != cur_b[31]) && (diff[31] != cur_a[31]);
          state  <= EVAL;
        end
        EVAL: begin
          resp_data  <= {31'b0, cond & ~cmp_err};
          resp_err   <= cmp_err;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (resp_ack) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
